// File: rtl/field_dumper_pkg.sv
// Shared types and constants for the field dumper and its UART transmitter.
package field_dumper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    FILL,
    SEND,
    CKSUM,
    DRAIN
  } dumper_state_t;

  localparam logic [7:0] DUMP_HEADER     = 8'hA5;
  localparam int         UART_DATA_BITS  = 8;
  localparam int         UART_STOP_BITS  = 1;
  localparam int         UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

endpackage

// File: rtl/field_dumper_uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte handshake.
// Ready is also high in the last cycle of the stop bit, so back-to-back bytes leave no idle gap.
module uart_tx
  import field_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 218
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_FRAME_BITS);

  logic [CW-1:0]             clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS:0]   shift_q, shift_d;
  logic                      busy_q, busy_d;
  logic                      tx_q, tx_d;
  logic                      last_cycle;
  logic                      accept;

  assign last_cycle = busy_q && (clk_cnt_q == '0) && (bit_cnt_q == '0);
  assign o_ready    = !busy_q || last_cycle;
  assign accept     = i_valid && o_ready;
  assign o_busy     = busy_q;
  assign o_tx       = tx_q;

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    tx_d      = tx_q;
    if (accept) begin
      // start bit goes out now; data bits then the stop bit wait in the shifter
      shift_d   = {1'b1, i_data};
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      clk_cnt_d = CW'(CLKS_PER_BIT - 1);
      bit_cnt_d = BW'(UART_FRAME_BITS - 1);
    end else if (busy_q) begin
      if (clk_cnt_q != '0) begin
        clk_cnt_d = clk_cnt_q - CW'(1);
      end else if (bit_cnt_q == '0) begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
      end else begin
        tx_d      = shift_q[0];
        shift_d   = {1'b1, shift_q[UART_DATA_BITS:1]};
        bit_cnt_d = bit_cnt_q - BW'(1);
        clk_cnt_d = CW'(CLKS_PER_BIT - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '1;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/field_dumper.sv
// Streams the displayed field over UART: header, packed cells (LSB = first cell), optional XOR byte.
// FIELD_DUMPER_CHECKSUM_EN appends the checksum byte; undefined builds drop it entirely.
//   state  | meaning
//   IDLE   | waiting for i_go
//   HEADER | header byte handed to the UART
//   FILL   | reading up to 8 cells into the assembly register
//   SEND   | waiting to hand the assembled byte to the UART
//   CKSUM  | checksum byte handed to the UART
//   DRAIN  | waiting for the last stop bit to finish
module field_dumper
  import field_dumper_pkg::*;
#(
  parameter int         FIELD_W      = 320,
  parameter int         FIELD_H      = 240,
  parameter int         CLKS_PER_BIT = 218,
  parameter logic [7:0] HEADER_BYTE  = DUMP_HEADER
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_go,
  input  logic                       i_cell_state,
  output logic                       o_is_dumping,
  output logic [$clog2(FIELD_W)-1:0] o_cur_x,
  output logic [$clog2(FIELD_H)-1:0] o_cur_y,
  output logic                       o_uart_tx
);

  localparam int XW         = $clog2(FIELD_W);
  localparam int YW         = $clog2(FIELD_H);
  localparam int NCELLS     = FIELD_W * FIELD_H;
  localparam int NBYTES     = (NCELLS + 7) / 8;
  localparam int BCW        = $clog2(NBYTES + 1);
  localparam int LAST_CELLS = NCELLS - 8 * (NBYTES - 1);

  dumper_state_t   state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [BCW-1:0]  byte_q, byte_d;
  logic [3:0]      fill_q, fill_d;
  logic            pend_q, pend_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      asm_q, asm_d;
`ifdef FIELD_DUMPER_CHECKSUM_EN
  logic [7:0]      cks_q, cks_d;
`endif

  logic       tx_valid, tx_ready, tx_busy;
  logic [7:0] tx_data;
  logic       last_byte, last_cell;
  logic [3:0] cells_this;

  assign last_byte  = (byte_q == BCW'(NBYTES - 1));
  assign last_cell  = (x_q == XW'(FIELD_W - 1)) && (y_q == YW'(FIELD_H - 1));
  assign cells_this = last_byte ? 4'(LAST_CELLS) : 4'd8;

  assign o_is_dumping = (state_q != IDLE);
  assign o_cur_x      = x_q;
  assign o_cur_y      = y_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    byte_d   = byte_q;
    fill_d   = fill_q;
    pend_d   = 1'b0;
    idx_d    = idx_q;
    asm_d    = asm_q;
`ifdef FIELD_DUMPER_CHECKSUM_EN
    cks_d    = cks_q;
`endif
    tx_valid = 1'b0;
    tx_data  = asm_q;

    // read data from the previous cycle's address lands here
    if (pend_q) asm_d[idx_q] = i_cell_state;

    case (state_q)
      IDLE: begin
        if (i_go) begin
          state_d = HEADER;
          x_d     = '0;
          y_d     = '0;
          byte_d  = '0;
`ifdef FIELD_DUMPER_CHECKSUM_EN
          cks_d   = '0;
`endif
        end
      end
      HEADER: begin
        tx_valid = !tx_busy;
        tx_data  = HEADER_BYTE;
        if (tx_valid && tx_ready) begin
          state_d = FILL;
          fill_d  = '0;
          asm_d   = '0;
        end
      end
      FILL: begin
        if (fill_q < cells_this) begin
          pend_d = 1'b1;
          idx_d  = fill_q[2:0];
          fill_d = fill_q + 4'd1;
          if (!last_cell) begin
            if (x_q == XW'(FIELD_W - 1)) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          byte_d = byte_q + BCW'(1);
          asm_d  = '0;
          fill_d = '0;
`ifdef FIELD_DUMPER_CHECKSUM_EN
          cks_d   = cks_q ^ asm_q;
          state_d = last_byte ? CKSUM : FILL;
`else
          state_d = last_byte ? DRAIN : FILL;
`endif
        end
      end
`ifdef FIELD_DUMPER_CHECKSUM_EN
      CKSUM: begin
        tx_valid = 1'b1;
        tx_data  = cks_q;
        if (tx_ready) state_d = DRAIN;
      end
`endif
      DRAIN: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      byte_q  <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      asm_q   <= '0;
`ifdef FIELD_DUMPER_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      byte_q  <= byte_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
`ifdef FIELD_DUMPER_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (tx_data),
    .i_valid(tx_valid),
    .o_ready(tx_ready),
    .o_busy (tx_busy),
    .o_tx   (o_uart_tx)
  );

endmodule

// File: tb/tb_field_dumper.sv
// Directed bench: a 4x4 and a 3x3 dumper, each with a 1-cycle behavioural field RAM and a line sampler.
module tb_field_dumper;

`ifdef FIELD_DUMPER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go_a, go_b;
  logic       cell_a, cell_b;
  logic       dump_a, dump_b;
  logic [1:0] x_a, y_a, x_b, y_b;
  logic       tx_a, tx_b;

  bit         mem_a [16];
  bit         mem_b [9];
  logic [7:0] rx [4];
  int         addr_q [$];
  logic [9:0] hdr_line;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  field_dumper #(.FIELD_W(4), .FIELD_H(4), .CLKS_PER_BIT(4), .HEADER_BYTE(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_go(go_a), .i_cell_state(cell_a),
    .o_is_dumping(dump_a), .o_cur_x(x_a), .o_cur_y(y_a), .o_uart_tx(tx_a));

  field_dumper #(.FIELD_W(3), .FIELD_H(3), .CLKS_PER_BIT(4), .HEADER_BYTE(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_go(go_b), .i_cell_state(cell_b),
    .o_is_dumping(dump_b), .o_cur_x(x_b), .o_cur_y(y_b), .o_uart_tx(tx_b));

  always @(posedge clk) begin
    cell_a <= mem_a[int'(y_a) * 4 + int'(x_a)];
    cell_b <= mem_b[(int'(y_b) * 3 + int'(x_b)) % 9];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 1) ? tx_b : tx_a;
  endfunction

  function automatic logic dump_of(input int sel);
    return (sel == 1) ? dump_b : dump_a;
  endfunction

  // Entered on a negedge with the DUT idle; leaves on the negedge of the first start-bit cycle.
  task automatic start_frame(input int sel);
    if (sel == 1) go_b = 1'b1; else go_a = 1'b1;
    @(negedge clk);
    check("start_dumping_t1", dump_of(sel), 1'b1);
    check("start_line_high_t1", tx_of(sel), 1'b1);
    go_a = 1'b0;
    go_b = 1'b0;
    @(negedge clk);
    check("start_bit_t2", tx_of(sel), 1'b0);
  endtask

  // Samples nb back-to-back 10-bit frames with no resynchronisation, so any gap breaks decoding.
  task automatic capture(input int sel, input int nb, input bit pulse_go);
    logic [7:0] cur;
    logic       t;
    int         pos, bi, last_addr, a;
    cur = '0;
    last_addr = 0;
    addr_q.delete();
    addr_q.push_back(0);
    for (int k = 0; k < nb * 40; k++) begin
      if (k > 0) @(negedge clk);
      t = tx_of(sel);
      if (sel == 1) begin
        a = int'(y_b) * 3 + int'(x_b);
        if (a != last_addr) begin
          last_addr = a;
          addr_q.push_back(a);
        end
      end
      pos = k % 40;
      bi  = pos / 4;
      if (k < 40) check("hdr_bit_timing", t, hdr_line[bi]);
      if (pos % 4 == 2) begin
        if (bi == 0) check("start_bit", t, 1'b0);
        else if (bi <= 8) cur[bi-1] = t;
        else begin
          check("stop_bit", t, 1'b1);
          rx[k / 40] = cur;
        end
      end
      if (pulse_go) go_a = (k % 10 == 0);
    end
    go_a = 1'b0;
    check("dumping_during_last_stop", dump_of(sel), 1'b1);
    @(negedge clk);
    check("dumping_falls_after_stop", dump_of(sel), 1'b0);
    check("line_idle_after_frame", tx_of(sel), 1'b1);
  endtask

  task automatic idle_check(input int sel, input int n);
    bit bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (tx_of(sel) !== 1'b1 || dump_of(sel) !== 1'b0) bad = 1'b1;
    end
    check("no_extra_frame", bad, 1'b0);
  endtask

  initial begin
    hdr_line = 10'b11_0100_1010;
    rst_n = 1'b0;
    go_a  = 1'b0;
    go_b  = 1'b0;
    for (int i = 0; i < 16; i++) mem_a[i] = (((i % 4) + (i / 4)) % 2) == 1;
    for (int i = 0; i < 9; i++) mem_b[i] = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_dump_a", dump_a, 1'b0);
    check("rst_x_a", x_a, 2'd0);
    check("rst_y_a", y_a, 2'd0);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_dump_b", dump_b, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // checkerboard, with i_go hammered during the frame
    start_frame(0);
    capture(0, 3 + CK, 1'b1);
    check("cb_header", rx[0], 8'hA5);
    check("cb_byte0", rx[1], 8'h5A);
    check("cb_byte1", rx[2], 8'h5A);
`ifdef FIELD_DUMPER_CHECKSUM_EN
    check("cb_cksum", rx[3], 8'h00);
`endif
    idle_check(0, 60);

    // 3x3 all alive: padded final byte and address walk
    start_frame(1);
    capture(1, 3 + CK, 1'b0);
    check("pad_header", rx[0], 8'hA5);
    check("pad_byte0", rx[1], 8'hFF);
    check("pad_byte1", rx[2], 8'h01);
`ifdef FIELD_DUMPER_CHECKSUM_EN
    check("pad_cksum", rx[3], 8'hFE);
`endif
    check("pad_addr_count", addr_q.size(), 9);
    for (int i = 0; i < addr_q.size() && i < 9; i++) check("pad_addr_seq", addr_q[i], i);
    check("pad_hold_x", x_b, 2'd2);
    check("pad_hold_y", y_b, 2'd2);
    idle_check(1, 20);

    // first 12 cells alive: payload FF, 0F
    for (int i = 0; i < 16; i++) mem_a[i] = (i < 12);
    start_frame(0);
    capture(0, 3 + CK, 1'b0);
    check("ff0f_header", rx[0], 8'hA5);
    check("ff0f_byte0", rx[1], 8'hFF);
    check("ff0f_byte1", rx[2], 8'h0F);
`ifdef FIELD_DUMPER_CHECKSUM_EN
    check("ff0f_cksum", rx[3], 8'hF0);
`endif
    idle_check(0, 50);

    // reset during data bit 3 of the first payload byte (empty field, so the line is low)
    for (int i = 0; i < 16; i++) mem_a[i] = 1'b0;
    start_frame(0);
    repeat (57) @(negedge clk);
    check("pre_reset_bit3", tx_a, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tx", tx_a, 1'b1);
    check("midrst_dump", dump_a, 1'b0);
    check("midrst_x", x_a, 2'd0);
    check("midrst_y", y_a, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) mem_a[i] = (((i % 4) + (i / 4)) % 2) == 1;
    start_frame(0);
    capture(0, 3 + CK, 1'b0);
    check("post_rst_header", rx[0], 8'hA5);
    check("post_rst_byte0", rx[1], 8'h5A);
    check("post_rst_byte1", rx[2], 8'h5A);
`ifdef FIELD_DUMPER_CHECKSUM_EN
    check("post_rst_cksum", rx[3], 8'h00);
`endif
    idle_check(0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
